// File: rtl/aes_stream_pkg.sv
// Shared definitions for the AES byte-stream datapath: block size, mode
// encodings, skid buffer state encodings and the buffered beat layout.
package aes_stream_pkg;

   localparam int   AES_BLOCK_BYTES = 16;

   localparam logic MODE_ENC = 1'b0;
   localparam logic MODE_DEC = 1'b1;

   typedef enum logic [1:0] {
      SKID_EMPTY = 2'b00,
      SKID_ONE   = 2'b01,
      SKID_FULL  = 2'b10
   } skid_state_e;

   // One buffered beat: the byte plus its end-of-block marker.
   typedef struct packed {
      logic       last;
      logic [7:0] data;
   } byte_beat_t;

   // A buffer accepts a new beat whenever it is not already holding two.
   function automatic logic skid_has_room(input skid_state_e st);
      return (st != SKID_FULL);
   endfunction

endpackage

// File: rtl/skid_buf_8.sv
// Two-entry valid/ready skid buffer for one 9-bit beat (data + last).
// Output valid/beat and input ready all come straight from registers, so
// the upstream ready never depends combinationally on out_ready.
module skid_buf_8
   import aes_stream_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  byte_beat_t in_beat,
   input  logic       in_valid,
   output logic       in_ready,
   output byte_beat_t out_beat,
   output logic       out_valid,
   input  logic       out_ready
);

   skid_state_e state_r;
   byte_beat_t  head_r;
   byte_beat_t  tail_r;
   logic        valid_r;
   logic        ready_r;
   logic        push_s;
   logic        pop_s;

   assign push_s    = in_valid && ready_r;
   assign pop_s     = valid_r && out_ready;
   assign in_ready  = ready_r;
   assign out_valid = valid_r;
   assign out_beat  = head_r;

   // Occupancy FSM: head_r is the presented beat, tail_r the skid slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= SKID_EMPTY;
         head_r  <= '0;
         tail_r  <= '0;
         valid_r <= 1'b0;
         ready_r <= 1'b1;
      end else begin
         case (state_r)
            SKID_EMPTY: begin
               if (push_s) begin
                  head_r  <= in_beat;
                  valid_r <= 1'b1;
                  state_r <= SKID_ONE;
               end
            end
            SKID_ONE: begin
               if (push_s && pop_s) begin
                  head_r <= in_beat;
               end else if (push_s) begin
                  tail_r  <= in_beat;
                  ready_r <= skid_has_room(SKID_FULL);
                  state_r <= SKID_FULL;
               end else if (pop_s) begin
                  valid_r <= 1'b0;
                  state_r <= SKID_EMPTY;
               end
            end
            SKID_FULL: begin
               // ready_r is low here, so only a pop can occur.
               if (pop_s) begin
                  head_r  <= tail_r;
                  ready_r <= 1'b1;
                  state_r <= SKID_ONE;
               end
            end
            default: begin
               valid_r <= 1'b0;
               ready_r <= 1'b1;
               state_r <= SKID_EMPTY;
            end
         endcase
      end
   end

endmodule

// File: rtl/byte_route_demux_8.sv
// Byte-stream demultiplexer feeding the forward (A, encrypt) or inverse
// (B, decrypt) S-box path. The mode is sampled on byte 0 of each block and
// the whole block follows it. Each channel has its own skid buffer.
// Optional feature macro: SELECT_STATS_EN adds per-channel block counters.
module byte_route_demux_8
   import aes_stream_pkg::*;
#(
   parameter int BLOCK_BYTES = AES_BLOCK_BYTES,
   parameter int CNT_W       = 4
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  s_data,
   input  logic        s_mode,
   input  logic        s_valid,
   output logic        s_ready,
   output logic [7:0]  a_data,
   output logic        a_last,
   output logic        a_valid,
   input  logic        a_ready,
   output logic [7:0]  b_data,
   output logic        b_last,
   output logic        b_valid,
   input  logic        b_ready
`ifdef SELECT_STATS_EN
   ,
   output logic [15:0] a_blk_cnt,
   output logic [15:0] b_blk_cnt
`endif
);

   logic [CNT_W-1:0] idx_r;
   logic             mode_r;
   logic             first_s;
   logic             last_s;
   logic             sel_s;
   logic             accept_s;
   logic             a_push_s;
   logic             b_push_s;
   logic             a_in_ready_s;
   logic             b_in_ready_s;
   byte_beat_t       in_beat_s;
   byte_beat_t       a_beat_s;
   byte_beat_t       b_beat_s;

   // Route selection: byte 0 uses the live mode, later bytes the latched one.
   always_comb begin
      first_s   = (idx_r == '0);
      last_s    = (idx_r == CNT_W'(BLOCK_BYTES - 1));
      in_beat_s = '{last: last_s, data: s_data};
      if (first_s) begin
         sel_s = s_mode;
      end else begin
         sel_s = mode_r;
      end
      if (sel_s == MODE_DEC) begin
         s_ready  = b_in_ready_s;
         a_push_s = 1'b0;
         b_push_s = s_valid;
      end else begin
         s_ready  = a_in_ready_s;
         a_push_s = s_valid;
         b_push_s = 1'b0;
      end
      accept_s = s_valid && s_ready;
   end

   // Byte index within the block and the per-block mode latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_r  <= '0;
         mode_r <= MODE_ENC;
      end else if (accept_s) begin
         if (first_s) begin
            mode_r <= s_mode;
         end
         if (last_s) begin
            idx_r <= '0;
         end else begin
            idx_r <= idx_r + CNT_W'(1);
         end
      end
   end

   skid_buf_8 u_skid_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_beat   (in_beat_s),
      .in_valid  (a_push_s),
      .in_ready  (a_in_ready_s),
      .out_beat  (a_beat_s),
      .out_valid (a_valid),
      .out_ready (a_ready)
   );

   skid_buf_8 u_skid_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_beat   (in_beat_s),
      .in_valid  (b_push_s),
      .in_ready  (b_in_ready_s),
      .out_beat  (b_beat_s),
      .out_valid (b_valid),
      .out_ready (b_ready)
   );

   assign a_data = a_beat_s.data;
   assign a_last = a_beat_s.last;
   assign b_data = b_beat_s.data;
   assign b_last = b_beat_s.last;

`ifdef SELECT_STATS_EN
   logic [15:0] a_blk_cnt_r;
   logic [15:0] b_blk_cnt_r;

   // Count completed blocks per channel on the handshake of their last byte.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_blk_cnt_r <= 16'h0000;
         b_blk_cnt_r <= 16'h0000;
      end else begin
         if (a_valid && a_ready && a_last) begin
            a_blk_cnt_r <= a_blk_cnt_r + 16'h0001;
         end
         if (b_valid && b_ready && b_last) begin
            b_blk_cnt_r <= b_blk_cnt_r + 16'h0001;
         end
      end
   end

   assign a_blk_cnt = a_blk_cnt_r;
   assign b_blk_cnt = b_blk_cnt_r;
`endif

endmodule

// File: tb/tb_byte_route_demux_8.sv
// Self-checking bench for byte_route_demux_8: a queue-based model of the
// two channels is compared against the DUT every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_byte_route_demux_8;

   logic       clk;
   logic       rst_n;
   logic [7:0] s_data;
   logic       s_mode;
   logic       s_valid;
   logic       s_ready;
   logic [7:0] a_data;
   logic       a_last;
   logic       a_valid;
   logic       a_ready;
   logic [7:0] b_data;
   logic       b_last;
   logic       b_valid;
   logic       b_ready;
`ifdef SELECT_STATS_EN
   logic [15:0] a_blk_cnt;
   logic [15:0] b_blk_cnt;
`endif

   byte_route_demux_8 dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .s_data  (s_data),
      .s_mode  (s_mode),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .a_data  (a_data),
      .a_last  (a_last),
      .a_valid (a_valid),
      .a_ready (a_ready),
      .b_data  (b_data),
      .b_last  (b_last),
      .b_valid (b_valid),
      .b_ready (b_ready)
`ifdef SELECT_STATS_EN
      ,
      .a_blk_cnt (a_blk_cnt),
      .b_blk_cnt (b_blk_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp = 0;
   int n_bad = 0;

   // Model: bytes accepted but not yet delivered, per channel, in order.
   logic [8:0] qa[$];
   logic [8:0] qb[$];
   int         m_idx = 0;
   logic       m_mode = 1'b0;
   int         m_blk_a = 0;
   int         m_blk_b = 0;

   // Values observed in the most recent cycle, for directed checks.
   logic       obs_s_ready, obs_acc;
   logic       obs_a_valid, obs_a_last, obs_b_valid, obs_b_last;
   logic [7:0] obs_a_data, obs_b_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      qa.delete();
      qb.delete();
      m_idx   = 0;
      m_mode  = 1'b0;
      m_blk_a = 0;
      m_blk_b = 0;
   endtask

   task automatic check_outputs();
      logic exp_sel;
      int   occ;
      chk("a_valid", {31'd0, a_valid}, {31'd0, (qa.size() != 0)});
      if (qa.size() != 0) chk("a_beat", {23'd0, a_last, a_data}, {23'd0, qa[0]});
      chk("b_valid", {31'd0, b_valid}, {31'd0, (qb.size() != 0)});
      if (qb.size() != 0) chk("b_beat", {23'd0, b_last, b_data}, {23'd0, qb[0]});
      exp_sel = (m_idx == 0) ? s_mode : m_mode;
      occ = exp_sel ? qb.size() : qa.size();
      chk("s_ready", {31'd0, s_ready}, {31'd0, (occ < 2)});
`ifdef SELECT_STATS_EN
      chk("a_blk_cnt", {16'd0, a_blk_cnt}, m_blk_a & 32'hFFFF);
      chk("b_blk_cnt", {16'd0, b_blk_cnt}, m_blk_b & 32'hFFFF);
`endif
   endtask

   // One clock: drive inputs after a falling edge, check, update model.
   task automatic cycle(input logic v, input logic [7:0] d, input logic m,
                        input logic ar, input logic br);
      logic sel;
      s_valid = v;
      s_data  = d;
      s_mode  = m;
      a_ready = ar;
      b_ready = br;
      #1;
      check_outputs();
      obs_s_ready = s_ready;
      obs_a_valid = a_valid; obs_a_data = a_data; obs_a_last = a_last;
      obs_b_valid = b_valid; obs_b_data = b_data; obs_b_last = b_last;
      obs_acc     = v && s_ready;
      if (a_valid && a_ready) begin
         chk("a_pop_nonempty", {31'd0, (qa.size() != 0)}, 32'd1);
         if (qa.size() != 0) begin
            if (qa[0][8]) m_blk_a++;
            void'(qa.pop_front());
         end
      end
      if (b_valid && b_ready) begin
         chk("b_pop_nonempty", {31'd0, (qb.size() != 0)}, 32'd1);
         if (qb.size() != 0) begin
            if (qb[0][8]) m_blk_b++;
            void'(qb.pop_front());
         end
      end
      if (obs_acc) begin
         sel = (m_idx == 0) ? m : m_mode;
         if (m_idx == 0) m_mode = m;
         if (sel) qb.push_back({(m_idx == 15), d});
         else     qa.push_back({(m_idx == 15), d});
         m_idx = (m_idx + 1) % 16;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   // Asynchronous reset asserted between clock edges; starts/ends at negedge.
   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_a_valid", {31'd0, a_valid}, 32'd0);
      chk("rst_b_valid", {31'd0, b_valid}, 32'd0);
      chk("rst_a_data", {23'd0, a_last, a_data}, 32'd0);
      chk("rst_b_data", {23'd0, b_last, b_data}, 32'd0);
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int nxt;
      int guard;
      rst_n = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_mode = 1'b0;
      a_ready = 1'b0; b_ready = 1'b0;
      @(negedge clk);
      do_reset();
      s_mode = 1'b0;
      #1 chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
      @(negedge clk);

      // 1: one block on A, full rate.
      for (int k = 0; k <= 16; k++) begin
         cycle(k < 16, 8'(k), 1'b0, 1'b1, 1'b1);
         if (k >= 1) begin
            chk("t1_a_valid", {31'd0, obs_a_valid}, 32'd1);
            chk("t1_a_data", {24'd0, obs_a_data}, k - 1);
            chk("t1_a_last", {31'd0, obs_a_last}, {31'd0, (k == 16)});
         end
         chk("t1_b_valid", {31'd0, obs_b_valid}, 32'd0);
      end

      // 2: block on B, mode toggled mid-block.
      for (int k = 0; k <= 16; k++) begin
         cycle(k < 16, 8'(8'h40 + k), (k == 0) ? 1'b1 : (k % 2 == 0), 1'b1, 1'b1);
         if (k >= 1) begin
            chk("t2_b_data", {24'd0, obs_b_data}, 8'h40 + k - 1);
            chk("t2_b_last", {31'd0, obs_b_last}, {31'd0, (k == 16)});
         end
         chk("t2_a_valid", {31'd0, obs_a_valid}, 32'd0);
      end

      // 3: A stalled, three bytes offered.
      cycle(1'b1, 8'hA1, 1'b0, 1'b0, 1'b1); chk("t3_rdy0", {31'd0, obs_s_ready}, 32'd1);
      cycle(1'b1, 8'hA2, 1'b0, 1'b0, 1'b1); chk("t3_rdy1", {31'd0, obs_s_ready}, 32'd1);
      cycle(1'b1, 8'hA3, 1'b0, 1'b0, 1'b1); chk("t3_rdy2", {31'd0, obs_s_ready}, 32'd0);
      cycle(1'b1, 8'hA3, 1'b0, 1'b1, 1'b1); chk("t3_out0", {24'd0, obs_a_data}, 32'hA1);
      chk("t3_rdy3", {31'd0, obs_s_ready}, 32'd0);
      cycle(1'b1, 8'hA3, 1'b0, 1'b1, 1'b1); chk("t3_out1", {24'd0, obs_a_data}, 32'hA2);
      chk("t3_acc", {31'd0, obs_acc}, 32'd1);
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1); chk("t3_out2", {24'd0, obs_a_data}, 32'hA3);
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1); chk("t3_empty", {31'd0, obs_a_valid}, 32'd0);

      // 4: rest of the A block with A stalled, then a B block.
      nxt = 3;
      for (int k = 0; k < 6; k++) begin
         cycle(1'b1, 8'(8'hC0 + nxt), 1'b1, 1'b0, 1'b1);
         if (obs_acc) nxt++;
         if (k >= 2) begin
            chk("t4_stall_rdy", {31'd0, obs_s_ready}, 32'd0);
            chk("t4_no_b", {31'd0, obs_b_valid}, 32'd0);
         end
      end
      guard = 0;
      while (nxt < 16 && guard < 64) begin
         cycle(1'b1, 8'(8'hC0 + nxt), 1'b1, 1'b1, 1'b1);
         if (obs_acc) nxt++;
         guard++;
      end
      chk("t4_a_block_done", nxt, 16);
      for (int k = 0; k < 16; k++) begin
         cycle(1'b1, 8'(8'hD0 + k), 1'b1, 1'b1, 1'b1);
         chk("t4_b_full_rate", {31'd0, obs_acc}, 32'd1);
      end
      for (int k = 0; k < 3; k++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);

      // 5: reset after byte 7 of a B block.
      for (int k = 0; k < 8; k++) cycle(1'b1, 8'(8'h70 + k), 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) cycle(1'b1, 8'(8'h70 + k), 1'b1, 1'b1, 1'b1);
      do_reset();
      cycle(1'b1, 8'h55, 1'b0, 1'b1, 1'b1);
      chk("t5_fresh_acc", {31'd0, obs_acc}, 32'd1);
      cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
      chk("t5_a_valid", {31'd0, obs_a_valid}, 32'd1);
      chk("t5_a_data", {24'd0, obs_a_data}, 32'h55);
      chk("t5_b_valid", {31'd0, obs_b_valid}, 32'd0);
      do_reset();

`ifdef SELECT_STATS_EN
      // 6: three blocks on A, two on B.
      for (int blk = 0; blk < 5; blk++)
         for (int k = 0; k < 16; k++)
            cycle(1'b1, 8'(k), (blk >= 3), 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      chk("t6_a_blk", {16'd0, a_blk_cnt}, 32'd3);
      chk("t6_b_blk", {16'd0, b_blk_cnt}, 32'd2);
      do_reset();
`endif

      // Random traffic with varying sink back-pressure.
      for (int ph = 0; ph < 4; ph++) begin
         for (int k = 0; k < 600; k++) begin
            cycle(($urandom % 4) != 0, 8'($urandom), 1'($urandom),
                  ($urandom % 4) < ph + 1, ($urandom % 4) >= ph);
         end
      end
      guard = 0;
      while ((qa.size() != 0 || qb.size() != 0) && guard < 16) begin
         cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
         guard++;
      end
      chk("drain_done", {31'd0, (qa.size() == 0 && qb.size() == 0)}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
